// File: rtl/bus_dest_regs.sv
// Destination register bank of the shared system bus (AR, PC, DR, AC, IR, TR)
// plus the registered bus-to-memory write port.
module bus_dest_regs #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [NREG-1:0]  ld,
    input  logic [NREG-1:0]  inr,
    input  logic [NREG-1:0]  clr,
    input  logic             mem_wr,
    output logic [WIDTH-1:0] ar_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] dr_out,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] tr_out,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             pc_wrap,
    output logic             conflict_err
);

    localparam int unsigned IdxAr = 0;
    localparam int unsigned IdxPc = 1;
    localparam int unsigned IdxDr = 2;
    localparam int unsigned IdxAc = 3;
    localparam int unsigned IdxIr = 4;
    localparam int unsigned IdxTr = 5;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             conflict_q, conflict_d;
    logic             pc_wrap_q, pc_wrap_d;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;

    always_comb begin
        conflict_d = conflict_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (clr[i]) begin
                regs_d[i] = '0;
            end else if (ld[i]) begin
                regs_d[i] = bus_in;
            end else if (inr[i]) begin
                regs_d[i] = regs_q[i] + 1'b1;
            end
            if ((ld[i] & inr[i]) | (ld[i] & clr[i]) | (inr[i] & clr[i])) begin
                conflict_d = 1'b1;
            end
        end
        // Only a pure increment counts as a wrap; clr or ld win priority over inr.
        pc_wrap_d = inr[IdxPc] & ~ld[IdxPc] & ~clr[IdxPc] & (regs_q[IdxPc] == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            conflict_q  <= 1'b0;
            pc_wrap_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            conflict_q <= conflict_d;
            pc_wrap_q  <= pc_wrap_d;
            mem_we_q   <= mem_wr;
            if (mem_wr) begin
                // Address is AR as it stood before this edge's update.
                mem_addr_q  <= regs_q[IdxAr];
                mem_wdata_q <= bus_in;
            end
        end
    end

    assign ar_out       = regs_q[IdxAr];
    assign pc_out       = regs_q[IdxPc];
    assign dr_out       = regs_q[IdxDr];
    assign ac_out       = regs_q[IdxAc];
    assign ir_out       = regs_q[IdxIr];
    assign tr_out       = regs_q[IdxTr];
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign pc_wrap      = pc_wrap_q;
    assign conflict_err = conflict_q;

endmodule

// File: doc/bus_dest_regs.md
Name: bus_dest_regs

Overview:
- Destination side of the shared 8-bit system bus: the register bank that captures the bus value into AR, PC, DR, AC, IR and TR.
- Also issues bus-to-memory write strobes.
- Its register outputs feed the bus source multiplexer; its load, increment and clear vectors come from the control sequencer.
- Every register is a loadable, incrementable, clearable counter.

Parameters:
- WIDTH, 8, bit width of the bus and of every register.
- NREG, 6, number of destination registers. Index map: 0=AR, 1=PC, 2=DR, 3=AC, 4=IR, 5=TR. Fixed at 6 in this design.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  current bus value from the source multiplexer.
- ld  input  NREG  per-register load-from-bus enable.
- inr  input  NREG  per-register increment enable.
- clr  input  NREG  per-register clear enable.
- mem_wr  input  1  request to write bus_in to memory at address AR.
- ar_out, pc_out, dr_out, ac_out, ir_out, tr_out  output  WIDTH each  register contents, fed back to the bus sources.
- mem_we  output  1  registered memory write strobe.
- mem_addr  output  WIDTH  registered write address.
- mem_wdata  output  WIDTH  registered write data.
- pc_wrap  output  1  one-cycle pulse when PC increments from all-ones to zero.
- conflict_err  output  1  sticky flag: two or more of ld/inr/clr asserted for the same register in the same cycle.

Behaviour:
- Reset: when rst=1 at a rising edge, all six registers, mem_we, mem_addr, mem_wdata, pc_wrap and conflict_err go to 0. rst overrides every other input in that cycle.
- Per-register update each edge, for register i, in priority order:
  - clr[i]=1: reg <= 0.
  - else ld[i]=1: reg <= bus_in.
  - else inr[i]=1: reg <= reg + 1, modulo 2^WIDTH (all-ones wraps to 0, no carry kept).
  - else: hold.
- Latency: an updated value is visible on *_out one cycle after the enabling edge. No combinational path from bus_in to any output.
- Register-to-register transfer through the bus works in one cycle: the source value driven on the bus is captured in the same cycle, e.g. ld[AR] with bus carrying PC. A self-load (ld[i] while the bus carries register i) keeps the old value.
- Multiple registers may be loaded from the bus in the same cycle; all capture the identical bus_in.
- pc_wrap = 1 for exactly one cycle, the cycle after an edge where an increment (no clr, no ld) moved PC from all-ones to 0. Otherwise 0.
- conflict_err:
  - Set on any edge where, for some i, more than one of ld[i], inr[i], clr[i] is 1.
  - Once set, stays 1 until rst.
  - The priority rule above still decides that register's update.
- Memory write:
  - mem_wr=1 at an edge: next cycle mem_we=1, mem_wdata = bus_in sampled at that edge, mem_addr = AR value before that edge's update (pre-update AR).
  - mem_wr=0: mem_we=0 next cycle; mem_addr and mem_wdata hold.
  - Back-to-back mem_wr gives continuous mem_we with per-cycle address and data.
- Reset mid-operation: a pending write (mem_wr sampled at the same edge as rst=1) is dropped, and mem_we=0 after reset.
- Enable bits with no effect: none. All NREG bits are significant.

Test Plan:
1. Reset: drive all enables and mem_wr with rst=1 for 2 cycles → all registers 0x00, mem_we=0, conflict_err=0, pc_wrap=0.
2. Load and transfer: bus_in=0x3C, ld[AR]=1 → ar_out=0x3C next cycle. Then bus_in=0x3C with ld[PC]=1 and ld[TR]=1 → pc_out=tr_out=0x3C, ar_out unchanged.
3. Increment wrap: load PC=0xFE, then inr[PC]=1 for 2 cycles → pc_out 0xFF then 0x00. pc_wrap=1 only in the cycle pc_out shows 0x00.
4. Priority and conflict: AC=0x55, then clr[AC]=ld[AC]=1 with bus_in=0xAA → ac_out=0x00, conflict_err=1. Further clean cycles leave conflict_err=1 until rst.
5. Memory write with simultaneous AR change: AR=0x10, mem_wr=1, inr[AR]=1, bus_in=0x77 → next cycle mem_we=1, mem_addr=0x10, mem_wdata=0x77, ar_out=0x11. mem_wr=0 next → mem_we=0, addr and data hold.
6. Reset during write: mem_wr=1 and rst=1 at the same edge → mem_we=0 and all registers 0x00 next cycle. Normal loads resume on the first edge after rst deasserts.
